pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register for the PipelineMIPS core, generalising the fixed D→E, E→M and M→W latch banks into one reusable block. It carries an opaque payload plus a flush-clearable control vector under a valid/ready handshake. It honours the hazard unit's stall and flush, and counts back-pressure cycles for performance analysis. An optional skid entry registers `in_ready`, which breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 35 +++
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register types and control-vector bit positions
// (the bit positions are shared with main_decoder).
package pipe_pkg;

  localparam int STALL_CNT_W = 32;
  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 48;

  localparam int CTRL_REG_WEN    = 0;
  localparam int CTRL_MEM_REN    = 1;
  localparam int CTRL_MEM_WEN    = 2;
  localparam int CTRL_RI         = 3;
  localparam int CTRL_BREAK      = 4;
  localparam int CTRL_SYSCALL    = 5;
  localparam int CTRL_ERET       = 6;
  localparam int CTRL_TLB_REFILL = 7;
  localparam int CTRL_TLB_INVAL  = 8;
  localparam int CTRL_TLB_MOD    = 9;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_CTRL_W-1:0] ctrl;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid holding register with valid bit; clear beats load beats drain.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_d
);

  logic         r_valid;
  logic [W-1:0] r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_d     <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_d     <= i_d;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_d     = r_d;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with stall/flush and back-pressure counter.
// Define PIPE_SKID_EN for a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int EW = DATA_W + CTRL_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t           w_in, w_skid, r_main;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_acc, w_fire, w_ld, w_skid_vld, w_cnt_inc;

  assign w_in   = '{data: in_data, ctrl: in_ctrl};
  assign w_fire = r_out_valid & out_ready & ~stall;
  assign w_ld   = ~r_out_valid | w_fire;
  assign w_acc  = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  // Skid only catches an accepted entry the main register cannot take this edge.
  pipe_skid_buf #(.W(EW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_acc & ~w_ld & ~flush),
    .i_drain (w_fire),
    .i_clear (flush),
    .i_d     (w_in),
    .o_valid (w_skid_vld),
    .o_d     (w_skid)
  );
  assign in_ready = ~w_skid_vld;
`else
  assign w_skid_vld = 1'b0;
  assign w_skid     = '0;
  assign in_ready   = w_ld;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_main      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_main.ctrl <= '0;
      if (CLEAR_DATA) r_main.data <= '0;
    end else if (w_ld) begin
      // Skid holds the older entry, so it always goes first.
      if (w_skid_vld) begin
        r_out_valid <= 1'b1;
        r_main      <= w_skid;
      end else if (w_acc) begin
        r_out_valid <= 1'b1;
        r_main      <= w_in;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_cnt_inc = r_out_valid & ~w_fire & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (w_cnt_inc && ~&r_cnt)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_main.data;
  assign out_ctrl  = r_main.ctrl;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (narrow payload, 4-bit stall counter).
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, stall, flush;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] stall_cnt;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall     (stall),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ctl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctl_of(d);
  endtask

  // One clock: report whether the offered entry was taken at this edge.
  task automatic cyc(output bit took);
    @(negedge clk);
    took = in_valid && in_ready && !flush;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected entries enter on acceptance, leave on transfer.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !stall) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'(sb.size()), 1);
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("sb_data", 32'(out_data), 32'(e.d));
          chk("sb_ctrl", 32'(out_ctrl), 32'(e.c));
        end
      end
      if (in_valid && in_ready) sb.push_back('{d: in_data, c: in_ctrl});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit t, got;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_cnt",   32'(stall_cnt), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_ctrl",  32'(out_ctrl), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DW'(i));
      cyc(t);
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_data",  32'(out_data), 32'(i));
    end
    drive(1'b0, '0);
    cyc(t);
    chk("stream_idle", 32'(out_valid), 0);
    chk("stream_cnt",  32'(stall_cnt), 0);

    // Stall 3 cycles holding 0xA with 0xB offered
    drive(1'b1, 16'hA);
    cyc(t);
    drive(1'b1, 16'hB);
    stall = 1'b1;
    #1;
`ifdef PIPE_SKID_EN
    chk("stall_rdy_first", 32'(in_ready), 1);
`else
    chk("stall_rdy_first", 32'(in_ready), 0);
`endif
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(t);
      got |= t;
      if (got) in_valid = 1'b0;
      if (k == 0) chk("stall_rdy_low", 32'(in_ready), 0);
    end
    chk("stall_cnt3",  32'(stall_cnt), 3);
    chk("stall_hold",  32'(out_data), 32'h000A);
    stall = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      cyc(t);
      got |= t;
    end
    in_valid = 1'b0;
    chk("stall_b_taken", 32'(got), 1);
    repeat (3) cyc(t);
    chk("stall_drained", 32'(out_valid), 0);
    chk("stall_sb_empty", 32'(sb.size()), 0);

    // Flush with main=0xA, skid=0xB (skid build), 0xC offered
    drive(1'b1, 16'hA);
    cyc(t);
    drive(1'b1, 16'hB);
    stall = 1'b1;
    cyc(t);
    stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 16'hC);
    cyc(t);
    flush = 1'b0;
    drive(1'b0, '0);
    #1;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ctrl",  32'(out_ctrl), 0);
    chk("flush_ready", 32'(in_ready), 1);
    chk("flush_data",  32'(out_data), 32'h000A);
    chk("flush_cnt_kept", 32'(stall_cnt), 4);
    repeat (3) cyc(t);
    chk("flush_no_c", 32'(out_valid), 0);

    // Stall and flush together
    drive(1'b1, 16'h7);
    cyc(t);
    drive(1'b0, '0);
    stall = 1'b1;
    flush = 1'b1;
    cyc(t);
    stall = 1'b0;
    flush = 1'b0;
    chk("sf_valid", 32'(out_valid), 0);
    chk("sf_ctrl",  32'(out_ctrl), 0);
    chk("sf_cnt",   32'(stall_cnt), 4);

    // Counter saturation
    out_ready = 1'b0;
    drive(1'b1, 16'h9);
    cyc(t);
    drive(1'b0, '0);
    repeat (20) cyc(t);
    chk("sat_cnt", 32'(stall_cnt), 15);
    repeat (3) cyc(t);
    chk("sat_hold_cnt", 32'(stall_cnt), 15);
    chk("sat_valid", 32'(out_valid), 1);
    chk("sat_data",  32'(out_data), 32'h0009);

    // Async reset between edges with data valid
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data",  32'(out_data), 0);
    chk("arst_ctrl",  32'(out_ctrl), 0);
    chk("arst_cnt",   32'(stall_cnt), 0);
    chk("arst_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h55);
    cyc(t);
    drive(1'b0, '0);
    chk("post_rst_acc",   32'(t), 1);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data",  32'(out_data), 32'h0055);
    chk("post_rst_ctrl",  32'(out_ctrl), 32'(ctl_of(16'h55)));
    cyc(t);
    chk("post_rst_idle", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
